// File: rtl/game_pkg.sv
// Shared game constants and the bomb controller state encoding.
package game_pkg;

   // Default playfield and bomb-physics parameters.
   localparam int unsigned DEF_SCREEN_W     = 640;
   localparam int unsigned DEF_SCREEN_H     = 480;
   localparam int unsigned DEF_BS_FLIGHT    = 3;
   localparam int unsigned DEF_EXPLODE_MAX  = 16;
   localparam int unsigned DEF_EXPLODE_STEP = 2;
   localparam int unsigned DEF_GRAVITY      = 1;
   localparam int unsigned DEF_VY_MAX       = 15;

   typedef enum logic [2:0] {
      StIdle,
      StFlight,
      StProbe,
      StExplode,
      StCrater
   } bomb_state_e;

endpackage

// File: rtl/bomb_controller.sv
// Bomb launch/flight/impact controller: ballistic kinematics, terrain probing, blast growth
// and a crater request handshake. Every output comes straight from a flop.
module bomb_controller
   import game_pkg::*;
#(
   parameter int unsigned SCREEN_W     = DEF_SCREEN_W,
   parameter int unsigned SCREEN_H     = DEF_SCREEN_H,
   parameter int unsigned BS_FLIGHT    = DEF_BS_FLIGHT,
   parameter int unsigned EXPLODE_MAX  = DEF_EXPLODE_MAX,
   parameter int unsigned EXPLODE_STEP = DEF_EXPLODE_STEP,
   parameter int unsigned GRAVITY      = DEF_GRAVITY,
   parameter int unsigned VY_MAX       = DEF_VY_MAX
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               frame_clk_rise,
   input  logic               fire,
   input  logic [9:0]         PX,
   input  logic [9:0]         PY,
   input  logic signed [5:0]  aim_vx,
   input  logic signed [5:0]  aim_vy,
   input  logic [511:0]       terrain_col,
   output logic [9:0]         terrain_col_x,
   output logic [9:0]         BX,
   output logic [9:0]         BY,
   output logic [9:0]         BS,
   output logic               bomb_visible,
   output logic               busy,
   output logic               crater_req,
   input  logic               crater_ack,
   output logic [9:0]         crater_x,
   output logic [9:0]         crater_y,
   output logic [9:0]         crater_r
);

   localparam logic signed [6:0] LP_VY_MAX = 7'(VY_MAX);

   bomb_state_e r_state, w_state_d;

   logic signed [10:0] r_x, w_x_d, r_y, w_y_d;
   logic signed [5:0]  r_vx, w_vx_d, r_vy, w_vy_d;
   logic [9:0]         r_bs, w_bs_d;
   logic               r_probe_wait, w_probe_wait_d;
   logic [9:0]         r_bx, w_bx_d, r_by, w_by_d;
   logic               r_vis, w_vis_d, r_busy, w_busy_d;
   logic               r_req, w_req_d;
   logic [9:0]         r_cx, w_cx_d, r_cy, w_cy_d, r_cr, w_cr_d;

   logic signed [10:0] w_x_step, w_y_step;
   logic signed [6:0]  w_vy_inc;
   logic signed [5:0]  w_vy_sat;
   logic               w_off_screen;
   logic [9:0]         w_bs_grow;
   logic               w_hit;

   // One frame of ballistic motion and the resulting off-screen test.
   always_comb begin
      w_x_step = r_x + $signed({{5{r_vx[5]}}, r_vx});
      w_y_step = r_y + $signed({{5{r_vy[5]}}, r_vy});
      w_vy_inc = $signed({r_vy[5], r_vy}) + $signed(7'(GRAVITY));
      w_vy_sat = (w_vy_inc > LP_VY_MAX) ? LP_VY_MAX[5:0] : w_vy_inc[5:0];
      // Negative y (above the screen) is legal; only the bottom edge ends the flight.
      w_off_screen = w_x_step[10] || (w_x_step[9:0] > 10'(SCREEN_W - 1)) ||
                     (!w_y_step[10] && (w_y_step[9:0] > 10'(SCREEN_H - 1)));
      w_bs_grow = r_bs + 10'(EXPLODE_STEP);
      // BY never exceeds SCREEN_H-1 while probing, so 9 bits index the column.
      w_hit = !r_y[10] && terrain_col[r_by[8:0]];
   end

   // Next-state, kinematics and registered-output values.
   always_comb begin
      w_state_d      = r_state;
      w_x_d          = r_x;
      w_y_d          = r_y;
      w_vx_d         = r_vx;
      w_vy_d         = r_vy;
      w_bs_d         = r_bs;
      w_probe_wait_d = r_probe_wait;
      w_req_d        = r_req;
      w_cx_d         = r_cx;
      w_cy_d         = r_cy;
      w_cr_d         = r_cr;

      unique case (r_state)
         StIdle: begin
            if (fire) begin
               w_x_d     = $signed({1'b0, PX});
               w_y_d     = $signed({1'b0, PY});
               w_vx_d    = aim_vx;
               w_vy_d    = aim_vy;
               w_bs_d    = 10'(BS_FLIGHT);
               w_state_d = StFlight;
            end
         end
         StFlight: begin
            if (frame_clk_rise) begin
               w_x_d  = w_x_step;
               w_y_d  = w_y_step;
               w_vy_d = w_vy_sat;
               if (w_off_screen) begin
                  w_state_d = StIdle;
               end else begin
                  w_state_d      = StProbe;
                  w_probe_wait_d = 1'b1;
               end
            end
         end
         StProbe: begin
            // First cycle lets the terrain column for the new BX arrive.
            if (r_probe_wait) begin
               w_probe_wait_d = 1'b0;
            end else begin
               w_state_d = w_hit ? StExplode : StFlight;
            end
         end
         StExplode: begin
            if (frame_clk_rise) begin
               if (w_bs_grow >= 10'(EXPLODE_MAX)) begin
                  w_bs_d    = 10'(EXPLODE_MAX);
                  w_state_d = StCrater;
                  w_req_d   = 1'b1;
                  w_cx_d    = r_bx;
                  w_cy_d    = r_by;
                  w_cr_d    = 10'(EXPLODE_MAX);
               end else begin
                  w_bs_d = w_bs_grow;
               end
            end
         end
         StCrater: begin
            if (r_req && crater_ack) begin
               w_state_d = StIdle;
               w_req_d   = 1'b0;
            end
         end
         default: w_state_d = StIdle;
      endcase

      if (w_state_d == StIdle) begin
         w_bs_d = '0;
      end

      w_bx_d   = w_x_d[9:0];
      w_by_d   = w_y_d[10] ? 10'd0 : w_y_d[9:0];
      w_vis_d  = ((w_state_d == StFlight) || (w_state_d == StProbe) ||
                  (w_state_d == StExplode)) && !w_y_d[10];
      w_busy_d = (w_state_d != StIdle);
   end

   // State, kinematics and output registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_state      <= StIdle;
         r_x          <= '0;
         r_y          <= '0;
         r_vx         <= '0;
         r_vy         <= '0;
         r_bs         <= '0;
         r_probe_wait <= 1'b0;
         r_bx         <= '0;
         r_by         <= '0;
         r_vis        <= 1'b0;
         r_busy       <= 1'b0;
         r_req        <= 1'b0;
         r_cx         <= '0;
         r_cy         <= '0;
         r_cr         <= '0;
      end else begin
         r_state      <= w_state_d;
         r_x          <= w_x_d;
         r_y          <= w_y_d;
         r_vx         <= w_vx_d;
         r_vy         <= w_vy_d;
         r_bs         <= w_bs_d;
         r_probe_wait <= w_probe_wait_d;
         r_bx         <= w_bx_d;
         r_by         <= w_by_d;
         r_vis        <= w_vis_d;
         r_busy       <= w_busy_d;
         r_req        <= w_req_d;
         r_cx         <= w_cx_d;
         r_cy         <= w_cy_d;
         r_cr         <= w_cr_d;
      end
   end

   assign terrain_col_x = r_bx;
   assign BX            = r_bx;
   assign BY            = r_by;
   assign BS            = r_bs;
   assign bomb_visible  = r_vis;
   assign busy          = r_busy;
   assign crater_req    = r_req;
   assign crater_x      = r_cx;
   assign crater_y      = r_cy;
   assign crater_r      = r_cr;

endmodule

// File: tb/tb_bomb_controller.sv
// Directed self-checking bench for bomb_controller.
module tb_bomb_controller;

   logic              Clk;
   logic              Reset_n;
   logic              frame_clk_rise;
   logic              fire;
   logic [9:0]        PX, PY;
   logic signed [5:0] aim_vx, aim_vy;
   logic [511:0]      terrain_col;
   logic [9:0]        terrain_col_x;
   logic [9:0]        BX, BY, BS;
   logic              bomb_visible, busy, crater_req, crater_ack;
   logic [9:0]        crater_x, crater_y, crater_r;

   int n_tests = 0;
   int n_fail  = 0;

   // Terrain model: one solid pixel at (t_col, t_row), or on every column when t_all.
   logic       t_en, t_all;
   logic [9:0] t_col;
   logic [8:0] t_row;

   bomb_controller dut (
      .Clk            (Clk),
      .Reset_n        (Reset_n),
      .frame_clk_rise (frame_clk_rise),
      .fire           (fire),
      .PX             (PX),
      .PY             (PY),
      .aim_vx         (aim_vx),
      .aim_vy         (aim_vy),
      .terrain_col    (terrain_col),
      .terrain_col_x  (terrain_col_x),
      .BX             (BX),
      .BY             (BY),
      .BS             (BS),
      .bomb_visible   (bomb_visible),
      .busy           (busy),
      .crater_req     (crater_req),
      .crater_ack     (crater_ack),
      .crater_x       (crater_x),
      .crater_y       (crater_y),
      .crater_r       (crater_r)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Terrain column arrives one cycle after terrain_col_x.
   always @(posedge Clk) begin
      terrain_col <= '0;
      if (t_en && (t_all || terrain_col_x == t_col)) terrain_col[t_row] <= 1'b1;
   end

   task automatic cyc();
      @(negedge Clk);
   endtask

   task automatic launch(input int px, input int py, input int vx, input int vy);
      PX = 10'(px); PY = 10'(py); aim_vx = 6'(vx); aim_vy = 6'(vy);
      fire = 1'b1;
      cyc();
      fire = 1'b0;
   endtask

   // One frame pulse plus enough quiet cycles for a full probe.
   task automatic frame();
      frame_clk_rise = 1'b1;
      cyc();
      frame_clk_rise = 1'b0;
      repeat (3) cyc();
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      repeat (2) cyc();
      Reset_n = 1'b1;
      n_tests++; if (BX !== 10'd0) begin n_fail++; $display("FAIL reset_bx: got %0d want 0", BX); end
      n_tests++; if (BY !== 10'd0) begin n_fail++; $display("FAIL reset_by: got %0d want 0", BY); end
      n_tests++; if (BS !== 10'd0) begin n_fail++; $display("FAIL reset_bs: got %0d want 0", BS); end
      n_tests++; if (terrain_col_x !== 10'd0) begin n_fail++; $display("FAIL reset_tcx: got %0d want 0", terrain_col_x); end
      n_tests++; if ({crater_x, crater_y, crater_r} !== 30'd0) begin n_fail++; $display("FAIL reset_crater: got %0d/%0d/%0d want 0/0/0", crater_x, crater_y, crater_r); end
      n_tests++; if ({bomb_visible, busy, crater_req} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got vis=%b busy=%b req=%b want 000", bomb_visible, busy, crater_req); end
      // Ack with no request outstanding must do nothing.
      crater_ack = 1'b1;
      cyc();
      crater_ack = 1'b0;
      cyc();
      n_tests++; if ({busy, crater_req} !== 2'b00) begin n_fail++; $display("FAIL idle_ack: got busy=%b req=%b want 00", busy, crater_req); end
   endtask

   task automatic test_flight();
      t_en = 1'b1; t_all = 1'b0; t_col = 10'd103; t_row = 9'd196;
      launch(100, 200, 3, -4);
      n_tests++; if ({BX, BY, BS} !== {10'd100, 10'd200, 10'd3}) begin n_fail++; $display("FAIL launch_pos: got %0d,%0d,%0d want 100,200,3", BX, BY, BS); end
      n_tests++; if ({bomb_visible, busy} !== 2'b11) begin n_fail++; $display("FAIL launch_flags: got vis=%b busy=%b want 11", bomb_visible, busy); end
      frame_clk_rise = 1'b1;
      cyc();
      frame_clk_rise = 1'b0;
      n_tests++; if ({BX, BY, BS} !== {10'd103, 10'd196, 10'd3}) begin n_fail++; $display("FAIL frame1_pos: got %0d,%0d,%0d want 103,196,3", BX, BY, BS); end
      n_tests++; if (terrain_col_x !== 10'd103) begin n_fail++; $display("FAIL frame1_tcx: got %0d want 103", terrain_col_x); end
      n_tests++; if (bomb_visible !== 1'b1) begin n_fail++; $display("FAIL frame1_vis: got %b want 1", bomb_visible); end
      repeat (2) cyc();
      n_tests++; if ({BS, busy, crater_req} !== {10'd3, 1'b1, 1'b0}) begin n_fail++; $display("FAIL probe_done: got bs=%0d busy=%b req=%b want 3,1,0", BS, busy, crater_req); end
   endtask

   task automatic test_explode();
      int exp_bs;
      exp_bs = 3;
      for (int i = 0; i < 7; i++) begin
         frame();
         exp_bs = (exp_bs + 2 >= 16) ? 16 : exp_bs + 2;
         n_tests++; if (BS !== 10'(exp_bs)) begin n_fail++; $display("FAIL explode_bs%0d: got %0d want %0d", i, BS, exp_bs); end
         if (i < 6) begin
            n_tests++; if (crater_req !== 1'b0) begin n_fail++; $display("FAIL early_req%0d: got %b want 0", i, crater_req); end
         end
      end
      n_tests++; if (crater_req !== 1'b1) begin n_fail++; $display("FAIL crater_req: got %b want 1", crater_req); end
      n_tests++; if ({crater_x, crater_y, crater_r} !== {10'd103, 10'd196, 10'd16}) begin n_fail++; $display("FAIL crater_data: got %0d,%0d,%0d want 103,196,16", crater_x, crater_y, crater_r); end
      n_tests++; if (bomb_visible !== 1'b0) begin n_fail++; $display("FAIL crater_vis: got %b want 0", bomb_visible); end
   endtask

   task automatic test_crater_handshake();
      t_en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         n_tests++; if ({crater_req, busy, crater_x, crater_y, crater_r} !== {1'b1, 1'b1, 10'd103, 10'd196, 10'd16}) begin
            n_fail++; $display("FAIL crater_hold%0d: got req=%b busy=%b %0d,%0d,%0d", i, crater_req, busy, crater_x, crater_y, crater_r);
         end
         cyc();
      end
      crater_ack = 1'b1;
      cyc();
      crater_ack = 1'b0;
      n_tests++; if ({crater_req, busy, bomb_visible} !== 3'b000) begin n_fail++; $display("FAIL ack_idle: got req=%b busy=%b vis=%b want 000", crater_req, busy, bomb_visible); end
      n_tests++; if (BS !== 10'd0) begin n_fail++; $display("FAIL ack_bs: got %0d want 0", BS); end
   endtask

   task automatic test_miss_right();
      launch(638, 100, 5, 0);
      n_tests++; if ({BX, busy} !== {10'd638, 1'b1}) begin n_fail++; $display("FAIL miss_launch: got bx=%0d busy=%b want 638,1", BX, busy); end
      frame();
      n_tests++; if ({busy, crater_req, bomb_visible} !== 3'b000) begin n_fail++; $display("FAIL miss_idle: got busy=%b req=%b vis=%b want 000", busy, crater_req, bomb_visible); end
      n_tests++; if (BS !== 10'd0) begin n_fail++; $display("FAIL miss_bs: got %0d want 0", BS); end
   endtask

   task automatic test_vy_saturate();
      launch(10, 0, 0, 14);
      frame();
      n_tests++; if (BY !== 10'd14) begin n_fail++; $display("FAIL sat_y1: got %0d want 14", BY); end
      frame();
      n_tests++; if (BY !== 10'd29) begin n_fail++; $display("FAIL sat_y2: got %0d want 29", BY); end
      frame();
      n_tests++; if (BY !== 10'd44) begin n_fail++; $display("FAIL sat_y3: got %0d want 44", BY); end
      Reset_n = 1'b0;
      cyc();
      Reset_n = 1'b1;
   endtask

   task automatic test_negative_y();
      t_en = 1'b1; t_all = 1'b1; t_row = 9'd0;
      launch(300, 2, 1, -8);
      n_tests++; if ({BY, bomb_visible} !== {10'd2, 1'b1}) begin n_fail++; $display("FAIL neg_launch: got by=%0d vis=%b want 2,1", BY, bomb_visible); end
      frame_clk_rise = 1'b1;
      cyc();
      n_tests++; if ({BX, BY, bomb_visible, busy} !== {10'd301, 10'd0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL neg_f1: got bx=%0d by=%0d vis=%b busy=%b want 301,0,0,1", BX, BY, bomb_visible, busy); end
      // Still high into the first probe cycle: must not move the bomb.
      cyc();
      frame_clk_rise = 1'b0;
      n_tests++; if (BX !== 10'd301) begin n_fail++; $display("FAIL probe_ignore: got bx=%0d want 301", BX); end
      repeat (2) cyc();
      for (int f = 2; f <= 17; f++) begin
         frame();
         if (f == 8) begin
            n_tests++; if ({BY, bomb_visible, BS} !== {10'd0, 1'b0, 10'd3}) begin n_fail++; $display("FAIL neg_f8: got by=%0d vis=%b bs=%0d want 0,0,3", BY, bomb_visible, BS); end
         end
      end
      n_tests++; if ({BX, BY} !== {10'd317, 10'd2}) begin n_fail++; $display("FAIL neg_f17: got %0d,%0d want 317,2", BX, BY); end
      n_tests++; if ({bomb_visible, busy, BS} !== {1'b1, 1'b1, 10'd3}) begin n_fail++; $display("FAIL neg_back: got vis=%b busy=%b bs=%0d want 1,1,3", bomb_visible, busy, BS); end
      t_en = 1'b0; t_all = 1'b0;
      Reset_n = 1'b0;
      cyc();
      Reset_n = 1'b1;
   endtask

   task automatic test_reset_mid();
      t_en = 1'b1; t_col = 10'd200; t_row = 9'd300;
      launch(200, 300, 0, 0);
      frame();
      frame();
      n_tests++; if ({BS, busy} !== {10'd5, 1'b1}) begin n_fail++; $display("FAIL mid_explode: got bs=%0d busy=%b want 5,1", BS, busy); end
      PX = 10'd50; PY = 10'd50; aim_vx = 6'sd1; aim_vy = 6'sd1;
      fire = 1'b1;
      cyc();
      fire = 1'b0;
      n_tests++; if ({BS, BX, busy} !== {10'd5, 10'd200, 1'b1}) begin n_fail++; $display("FAIL busy_fire: got bs=%0d bx=%0d busy=%b want 5,200,1", BS, BX, busy); end
      Reset_n = 1'b0;
      cyc();
      Reset_n = 1'b1;
      n_tests++; if ({BX, BY, BS, terrain_col_x} !== 40'd0) begin n_fail++; $display("FAIL mid_reset_pos: got %0d,%0d,%0d,%0d want 0", BX, BY, BS, terrain_col_x); end
      n_tests++; if ({bomb_visible, busy, crater_req} !== 3'b000) begin n_fail++; $display("FAIL mid_reset_flags: got vis=%b busy=%b req=%b want 000", bomb_visible, busy, crater_req); end
      t_en = 1'b0;
      repeat (5) cyc();
      n_tests++; if ({busy, crater_req, BS} !== {1'b0, 1'b0, 10'd0}) begin n_fail++; $display("FAIL no_relaunch: got busy=%b req=%b bs=%0d want 0,0,0", busy, crater_req, BS); end
   endtask

   initial begin
      Reset_n = 1'b0; frame_clk_rise = 1'b0; fire = 1'b0; crater_ack = 1'b0;
      PX = '0; PY = '0; aim_vx = '0; aim_vy = '0;
      t_en = 1'b0; t_all = 1'b0; t_col = '0; t_row = '0;
      cyc();
      test_reset();
      test_flight();
      test_explode();
      test_crater_handshake();
      test_miss_right();
      test_vy_saturate();
      test_negative_y();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
